// File: rtl/kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard controller.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } kbd_state_e;

  localparam logic [7:0] KBD_EXT = 8'hE0;
  localparam logic [7:0] KBD_BRK = 8'hF0;

endpackage

// File: rtl/kbd_decode.sv
// Combinational scan-code classification: prefix detection and comparison against the held key.
module kbd_decode
  import kbd_pkg::*;
(
  input  logic [7:0] code_i,
  input  logic       ext_pend_i,
  input  logic [7:0] key_code_i,
  input  logic       key_ext_i,
  input  logic       key_valid_i,
  output logic       is_ext_o,
  output logic       is_brk_o,
  output logic       match_o
);

  assign is_ext_o = (code_i == KBD_EXT);
  assign is_brk_o = (code_i == KBD_BRK);
  // A byte refers to the held key only if both the code and its E0 qualification agree.
  assign match_o  = key_valid_i && (code_i == key_code_i) && (ext_pend_i == key_ext_i);

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 scan-code consumer: pops one FIFO byte per three cycles and tracks the held key.
module kbd_ctrl
  import kbd_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fifo_ready,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_overflow,
  output logic             fifo_nextdata_n,
  input  logic             ovf_clr,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_cnt,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             overflow_sticky
);

  kbd_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       key_code_q, key_code_d;
  logic             key_ext_q, key_ext_d;
  logic             key_valid_q, key_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             ovf_q, ovf_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;

  logic             ext_eff, brk_eff;
  logic             is_ext, is_brk, match;

  // Overflow resynchronises the prefix tracker before any byte in the same cycle is decoded.
  assign ext_eff = ext_q & ~fifo_overflow;
  assign brk_eff = brk_q & ~fifo_overflow;

  kbd_decode u_decode (
    .code_i      (byte_q),
    .ext_pend_i  (ext_eff),
    .key_code_i  (key_code_q),
    .key_ext_i   (key_ext_q),
    .key_valid_i (key_valid_q),
    .is_ext_o    (is_ext),
    .is_brk_o    (is_brk),
    .match_o     (match)
  );

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = key_valid_q;
    cnt_d       = cnt_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    ext_d       = ext_eff;
    brk_d       = brk_eff;
    ovf_d       = fifo_overflow ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    unique case (state_q)
      IDLE: begin
        if (fifo_ready) begin
          byte_d  = fifo_data;
          state_d = POP;
        end
      end
      POP: begin
        state_d = GAP;
        if (is_ext) begin
          ext_d = 1'b1;
        end else if (is_brk) begin
          brk_d = 1'b1;
        end else begin
          if (brk_eff) begin
            if (match) begin
              key_valid_d = 1'b0;
              release_d   = 1'b1;
            end
          end else if (!match) begin
            // Typematic repeats of the held key are absorbed; anything else is a new press.
            key_code_d  = byte_q;
            key_ext_d   = ext_eff;
            key_valid_d = 1'b1;
            cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            press_d     = 1'b1;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      ovf_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      ovf_q       <= ovf_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
    end
  end

  assign fifo_nextdata_n = (state_q != POP);
  assign key_code        = key_code_q;
  assign key_ext         = key_ext_q;
  assign key_valid       = key_valid_q;
  assign press_cnt       = cnt_q;
  assign press_pulse     = press_q;
  assign release_pulse   = release_q;
  assign overflow_sticky = ovf_q;

endmodule

// File: tb/tb_kbd_ctrl.sv
// Bench for kbd_ctrl: directed scan-code sequences plus random traffic against a byte-level key model.
module tb_kbd_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fifo_ready;
  logic [7:0]  fifo_data;
  logic        fifo_overflow;
  logic        ovf_clr;

  logic        nxt_n, kv, kx, pp, rp, ovs;
  logic [7:0]  kc;
  logic [15:0] cnt;
  logic        nxt4_n, kv4, kx4, pp4, rp4, ovs4;
  logic [7:0]  kc4;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;
  int np, nr;

  // Reference model state: what a keyboard user sees, one byte at a time.
  logic [7:0]  m_code;
  logic        m_ext, m_valid, m_extp, m_brkp, m_press, m_rel;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  kbd_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
    .fifo_overflow(fifo_overflow), .fifo_nextdata_n(nxt_n), .ovf_clr(ovf_clr),
    .key_code(kc), .key_ext(kx), .key_valid(kv), .press_cnt(cnt),
    .press_pulse(pp), .release_pulse(rp), .overflow_sticky(ovs)
  );

  kbd_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
    .fifo_overflow(fifo_overflow), .fifo_nextdata_n(nxt4_n), .ovf_clr(ovf_clr),
    .key_code(kc4), .key_ext(kx4), .key_valid(kv4), .press_cnt(cnt4),
    .press_pulse(pp4), .release_pulse(rp4), .overflow_sticky(ovs4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00; m_ext = 1'b0; m_valid = 1'b0;
    m_extp = 1'b0; m_brkp = 1'b0; m_cnt = 0; m_press = 1'b0; m_rel = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic held;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0) m_brkp = 1'b1;
    else begin
      held = m_valid && (b == m_code) && (m_extp == m_ext);
      if (m_brkp) begin
        if (held) begin m_valid = 1'b0; m_rel = 1'b1; end
      end else if (!held) begin
        m_code = b; m_ext = m_extp; m_valid = 1'b1; m_cnt++; m_press = 1'b1;
      end
      m_extp = 1'b0;
      m_brkp = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".code"},  kc,   m_code);
    chk({tag, ".ext"},   kx,   m_ext);
    chk({tag, ".valid"}, kv,   m_valid);
    chk({tag, ".cnt"},   cnt,  m_cnt % 65536);
    chk({tag, ".cnt4"},  cnt4, m_cnt % 16);
    chk({tag, ".code4"}, {kx4, kv4, kc4}, {m_ext, m_valid, m_code});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    fifo_ready = 1'b1;
    fifo_data  = b;
    @(negedge clk);
    chk("pop_strobe", {nxt_n, nxt4_n}, 2'b00);
    fifo_ready = 1'b0;
    model_byte(b);
    @(negedge clk);
    check_state("byte");
    chk("press_pulse",   {pp, pp4}, {2{m_press}});
    chk("release_pulse", {rp, rp4}, {2{m_rel}});
    np += int'(pp);
    nr += int'(rp);
  endtask

  task automatic ovf_pulse();
    @(negedge clk);
    fifo_overflow = 1'b1;
    @(negedge clk);
    fifo_overflow = 1'b0;
    m_extp = 1'b0;
    m_brkp = 1'b0;
  endtask

  logic [7:0] burst [4];
  logic [7:0] pool  [4];
  logic [7:0] rb;
  int pops, last, gaps_bad;

  initial begin
    resetn = 1'b0; fifo_ready = 1'b0; fifo_data = 8'h00;
    fifo_overflow = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #23;
    chk("rst_nxt",   {nxt_n, nxt4_n}, 2'b11);
    chk("rst_pulse", {pp, rp, ovs, pp4, rp4, ovs4}, 6'b0);
    check_state("rst");
    @(negedge clk);
    resetn = 1'b1;

    // Press and release.
    np = 0; nr = 0;
    send_byte(8'h16); send_byte(8'hF0); send_byte(8'h16);
    chk("s1_code", kc, 8'h16); chk("s1_valid", kv, 1'b0); chk("s1_cnt", cnt, 16'd1);
    chk("s1_np", np, 1); chk("s1_nr", nr, 1);

    // Typematic repeats.
    np = 0; nr = 0;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    chk("s2_cnt", cnt, 16'd2); chk("s2_np", np, 1); chk("s2_nr", nr, 1); chk("s2_valid", kv, 1'b0);

    // Extended key: plain break must not release it, E0 break must.
    np = 0; nr = 0;
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'h75);
    chk("s3_noplainrel", {kv, kx, kc}, {1'b1, 1'b1, 8'h75});
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("s3_code", kc, 8'h75); chk("s3_ext", kx, 1'b1); chk("s3_valid", kv, 1'b0);
    chk("s3_np", np, 1); chk("s3_nr", nr, 1);

    // Last key wins.
    send_byte(8'h21); send_byte(8'h22);
    chk("lkw_code", kc, 8'h22);

    // Burst with fifo_ready held: one strobe per byte, three cycles apart.
    burst[0] = 8'h31; burst[1] = 8'h32; burst[2] = 8'h33; burst[3] = 8'h34;
    pops = 0; last = -1; gaps_bad = 0;
    @(negedge clk);
    fifo_ready = 1'b1;
    fifo_data  = burst[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!nxt_n) begin
        if (pops > 0 && (c - last) != 3) gaps_bad++;
        last = c;
        pops++;
        if (pops < 4) fifo_data = burst[pops];
        else fifo_ready = 1'b0;
      end
    end
    chk("burst_pops", pops, 4);
    chk("burst_gaps", gaps_bad, 0);
    for (int i = 0; i < 4; i++) model_byte(burst[i]);
    check_state("burst");

    // Overflow drops a pending E0 and a pending F0.
    send_byte(8'hE0); ovf_pulse(); send_byte(8'h3A);
    chk("resync_ext", kx, 1'b0);
    send_byte(8'hF0); ovf_pulse(); send_byte(8'h3A);
    chk("resync_held", kv, 1'b1);

    // Sticky overflow: set wins over clear, clear alone clears.
    @(negedge clk); fifo_overflow = 1'b1; ovf_clr = 1'b1;
    @(negedge clk); fifo_overflow = 1'b0; ovf_clr = 1'b0;
    chk("ovf_setwins", {ovs, ovs4}, 2'b11);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_clr", ovs, 1'b0);
    @(negedge clk); fifo_overflow = 1'b1;
    @(negedge clk); fifo_overflow = 1'b0;
    m_extp = 1'b0; m_brkp = 1'b0;

    // Random traffic.
    pool[0] = 8'h16; pool[1] = 8'h1C; pool[2] = 8'h75; pool[3] = 8'h3A;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0:       rb = 8'hE0;
        1:       rb = 8'hF0;
        2:       rb = 8'($urandom_range(0, 255));
        default: rb = pool[$urandom_range(0, 3)];
      endcase
      send_byte(rb);
      if ($urandom_range(0, 15) == 0) ovf_pulse();
    end

    // Reset during POP with an E0 pending.
    @(negedge clk); fifo_overflow = 1'b1;
    @(negedge clk); fifo_overflow = 1'b0;
    m_extp = 1'b0; m_brkp = 1'b0;
    send_byte(8'h44);
    send_byte(8'hE0);
    @(negedge clk); fifo_ready = 1'b1; fifo_data = 8'h75;
    @(negedge clk); fifo_ready = 1'b0;
    chk("pre_rst_pop", nxt_n, 1'b0);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst2_nxt", {nxt_n, nxt4_n}, 2'b11);
    chk("rst2_flags", {pp, rp, ovs}, 3'b0);
    check_state("rst2");
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    chk("rst2_nopop", nxt_n, 1'b1);
    send_byte(8'h75);
    chk("rst2_ext", kx, 1'b0); chk("rst2_cnt", cnt, 16'd1);

    // 17 distinct presses wrap the 4-bit counter to 1.
    for (int i = 0; i < 16; i++) send_byte((i % 2) ? 8'h11 : 8'h12);
    chk("wrap4", cnt4, 4'd1);
    chk("nowrap16", cnt, 16'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kbd_ctrl.md
KBD_CTRL -- requirements
Module: kbd_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of key-press counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fifo_ready  input  1  PS/2 receiver FIFO non-empty; fifo_data valid while high.
REQ-005 SHALL have port fifo_data  input  8  head-of-FIFO scan-code byte.
REQ-006 SHALL have port fifo_overflow  input  1  receiver FIFO overflow indication, level.
REQ-007 SHALL have port fifo_nextdata_n  output  1  active-low FIFO pop strobe, one cycle per byte.
REQ-008 SHALL have port ovf_clr  input  1  clears overflow_sticky.
REQ-009 SHALL have port key_code  output  8  make code of currently held key.
REQ-010 SHALL have port key_ext  output  1  held key used E0 prefix.
REQ-011 SHALL have port key_valid  output  1  a key is held; drives seven-segment enable.
REQ-012 SHALL have port press_cnt  output  CNT_W  count of distinct key presses.
REQ-013 SHALL have port press_pulse  output  1  one-cycle pulse per counted press.
REQ-014 SHALL have port release_pulse  output  1  one-cycle pulse when held key released.
REQ-015 SHALL have port overflow_sticky  output  1  latched overflow flag.

Function
REQ-016 SHALL run FSM with states IDLE, POP, GAP; IDLE->POP when fifo_ready=1 (byte_r<=fifo_data), POP->GAP unconditionally, GAP->IDLE unconditionally.
REQ-017 SHALL drive fifo_nextdata_n=0 only while in POP, 1 otherwise; max one byte per 3 cycles.
REQ-018 SHALL decode byte_r during POP; resulting output changes visible on cycle following POP (T+2 from fifo_ready sampled at T).
REQ-019 SHALL on byte 8'hE0 set ext_pending; no output change.
REQ-020 SHALL on byte 8'hF0 set brk_pending; no output change.
REQ-021 SHALL on other byte with brk_pending=1: if key_valid and byte==key_code and ext_pending==key_ext, clear key_valid and pulse release_pulse; else ignore; clear both pendings either way.
REQ-022 SHALL on other byte with brk_pending=0: if key_valid and byte==key_code and ext_pending==key_ext (typematic repeat), no change; else load key_code=byte, key_ext=ext_pending, key_valid=1, press_cnt+1, pulse press_pulse; clear ext_pending.
REQ-023 SHALL let a new make code while another key is held replace key_code and count as a press (last-key-wins).
REQ-024 SHALL keep key_code/key_ext unchanged on release; only key_valid falls.
REQ-025 SHALL wrap press_cnt modulo 2^CNT_W ({CNT_W{1}} -> 0).
REQ-026 SHALL set overflow_sticky when fifo_overflow=1, clear on ovf_clr=1; set wins when simultaneous.
REQ-027 SHALL clear ext_pending and brk_pending in any cycle fifo_overflow=1 (resync); a byte decoded that cycle is treated with pendings already cleared.
REQ-028 SHALL ignore fifo_ready in POP and GAP.

Reset
REQ-029 SHALL on resetn=0 asynchronously force state=IDLE, fifo_nextdata_n=1, key_code=0, key_ext=0, key_valid=0, press_cnt=0, press_pulse=0, release_pulse=0, overflow_sticky=0, byte_r=0, pendings=0.
REQ-030 SHALL discard any in-flight byte and pending prefix on reset mid-operation; no pop strobe issued after reset assertion.

Structure
REQ-031 SHALL place FSM state enum and constants KBD_EXT=8'hE0, KBD_BRK=8'hF0 in shared package kbd_pkg.
REQ-032 SHALL use one sub-module kbd_decode (combinational byte classification: ext/brk/code, match vs held key); FSM and registers stay in kbd_ctrl.

Verification
REQ-033 SHALL cover: bytes 16 then F0 16 -> key_code=16, key_valid 1 then 0, press_cnt=1, one press_pulse, one release_pulse.
REQ-034 SHALL cover: bytes 1C 1C 1C F0 1C (typematic) -> press_cnt=1, single press_pulse, key_valid=0 at end.
REQ-035 SHALL cover: bytes E0 75 then E0 F0 75 -> key_code=75, key_ext=1, press_cnt=1, release_pulse once; plain F0 75 instead -> no release.
REQ-036 SHALL cover: fifo_ready held high with 4 bytes -> fifo_nextdata_n low exactly 4 single cycles, 3 cycles apart.
REQ-037 SHALL cover: press_cnt preset path via 65536 distinct-press sequence (CNT_W=16) -> wraps to 0; CNT_W=4 with 17 presses -> 1.
REQ-038 SHALL cover: resetn low while in POP after E0 -> all outputs reset values; next byte 75 loads key_ext=0; fifo_overflow with ovf_clr same cycle -> overflow_sticky=1.
